// File: rtl/tile_raster_pipe.sv
// Tile rasteriser: scans a 2^TILE_BITS square tile one pixel per clock, tests three edge
// functions and clamped depth against an internal depth buffer, and emits colour writes.
module tile_raster_pipe #(
   parameter int TILE_BITS = 5,
   parameter int AW        = 19,
   parameter int BW        = 24,
   parameter int WW        = 32,
   parameter int ZW        = 27,
   parameter int CW        = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [AW-1:0]        A01_in,
   input  logic [AW-1:0]        A12_in,
   input  logic [AW-1:0]        A20_in,
   input  logic [BW-1:0]        B01_in,
   input  logic [BW-1:0]        B12_in,
   input  logic [BW-1:0]        B20_in,
   input  logic [WW-1:0]        w0_in,
   input  logic [WW-1:0]        w1_in,
   input  logic [WW-1:0]        w2_in,
   input  logic [ZW-1:0]        z0_in,
   input  logic [ZW-1:0]        dzdx_in,
   input  logic [ZW-1:0]        dzdy_in,
   input  logic [CW-1:0]        color_in,
   input  logic                 clear_in,
   input  logic [1:0]           depth_func_in,
   input  logic                 depth_write_in,
   output logic [TILE_BITS-1:0] X,
   output logic [TILE_BITS-1:0] Y,
   output logic                 wren,
   output logic [CW-1:0]        color_out,
   output logic                 busy,
   output logic                 done
);
   localparam int AD = 2 * TILE_BITS;
   localparam int N  = 1 << AD;
   localparam int ZA = ZW + 2;
   localparam logic [TILE_BITS-1:0] XMAX  = {TILE_BITS{1'b1}};
   localparam logic [TILE_BITS-1:0] ONE_T = {{(TILE_BITS-1){1'b0}}, 1'b1};
   localparam logic [ZW-1:0]        ZFAR  = {ZW{1'b1}};
   localparam logic [1:0] DF_LESS = 2'd0, DF_LEQUAL = 2'd1, DF_ALWAYS = 2'd2, DF_GREATER = 2'd3;

   logic [AW-1:0] a01_q, a01_d, a12_q, a12_d, a20_q, a20_d;
   logic [BW-1:0] b01_q, b01_d, b12_q, b12_d, b20_q, b20_d;
   logic [ZW-1:0] dzdx_q, dzdx_d, dzdy_q, dzdy_d;
   logic [CW-1:0] col_q, col_d;
   logic          clr_q, clr_d, dwr_q, dwr_d;
   logic [1:0]    func_q, func_d;
   logic [TILE_BITS-1:0] sx_q, sx_d, sy_q, sy_d;
   logic [WW-1:0] w0_q, w0_d, w1_q, w1_d, w2_q, w2_d, r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
   logic [ZA-1:0] z_q, z_d, zr_q, zr_d;
   logic          s0_v_q, s0_v_d;
   logic          s1_v_q, s1_v_d, s1_last_q, s1_last_d, s1_in_q, s1_in_d;
   logic [TILE_BITS-1:0] s1_x_q, s1_x_d, s1_y_q, s1_y_d;
   logic [ZW-1:0] s1_z_q, s1_z_d, zbuf_q;
   logic          s2_last_q, s2_last_d, wren_q, wren_d, busy_q, busy_d, done_q, done_d;
   logic [CW-1:0] color_out_q, color_out_d;
   logic [TILE_BITS-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
   logic [ZW-1:0] depth_mem [N];

   logic          start_ok_s, inside_s, zpass_s, pass_s, we_s;
   logic [WW-1:0] a01_s, a12_s, a20_s, b01_s, b12_s, b20_s;
   logic [ZA-1:0] dzdx_s, dzdy_s;
   logic [ZW-1:0] zclamp_s, wdata_s;

   assign start_ok_s = start & ~busy_q;
   assign a01_s  = WW'($signed(a01_q));
   assign a12_s  = WW'($signed(a12_q));
   assign a20_s  = WW'($signed(a20_q));
   assign b01_s  = WW'($signed(b01_q));
   assign b12_s  = WW'($signed(b12_q));
   assign b20_s  = WW'($signed(b20_q));
   assign dzdx_s = ZA'($signed(dzdx_q));
   assign dzdy_s = ZA'($signed(dzdy_q));

   // Pass configuration is captured once per accepted start and held for the whole scan.
   always_comb begin
      a01_d  = start_ok_s ? A01_in : a01_q;
      a12_d  = start_ok_s ? A12_in : a12_q;
      a20_d  = start_ok_s ? A20_in : a20_q;
      b01_d  = start_ok_s ? B01_in : b01_q;
      b12_d  = start_ok_s ? B12_in : b12_q;
      b20_d  = start_ok_s ? B20_in : b20_q;
      dzdx_d = start_ok_s ? dzdx_in : dzdx_q;
      dzdy_d = start_ok_s ? dzdy_in : dzdy_q;
      col_d  = start_ok_s ? color_in : col_q;
      clr_d  = start_ok_s ? clear_in : clr_q;
      func_d = start_ok_s ? depth_func_in : func_q;
      dwr_d  = start_ok_s ? depth_write_in : dwr_q;
   end

   // S0 scan: x steps add A; a row wrap steps the row-start accumulators by B instead.
   always_comb begin
      sx_d = sx_q;  sy_d = sy_q;  s0_v_d = s0_v_q;
      w0_d = w0_q;  w1_d = w1_q;  w2_d = w2_q;
      r0_d = r0_q;  r1_d = r1_q;  r2_d = r2_q;
      z_d  = z_q;   zr_d = zr_q;
      if (start_ok_s) begin
         sx_d = {TILE_BITS{1'b0}};
         sy_d = {TILE_BITS{1'b0}};
         w0_d = w0_in;  w1_d = w1_in;  w2_d = w2_in;
         r0_d = w0_in;  r1_d = w1_in;  r2_d = w2_in;
         z_d  = {2'b00, z0_in};
         zr_d = {2'b00, z0_in};
         s0_v_d = 1'b1;
      end else if (s0_v_q) begin
         if (sx_q == XMAX) begin
            sx_d = {TILE_BITS{1'b0}};
            sy_d = sy_q + ONE_T;
            r0_d = r0_q + b01_s;  w0_d = r0_q + b01_s;
            r1_d = r1_q + b12_s;  w1_d = r1_q + b12_s;
            r2_d = r2_q + b20_s;  w2_d = r2_q + b20_s;
            zr_d = zr_q + dzdy_s; z_d  = zr_q + dzdy_s;
            s0_v_d = (sy_q != XMAX);
         end else begin
            sx_d = sx_q + ONE_T;
            w0_d = w0_q + a01_s;
            w1_d = w1_q + a12_s;
            w2_d = w2_q + a20_s;
            z_d  = z_q + dzdx_s;
         end
      end else begin
         s0_v_d = 1'b0;
      end
   end

   // Depth clamp to [0, far] and the inside test on edge sign bits.
   always_comb begin
      if (z_q[ZA-1]) begin
         zclamp_s = {ZW{1'b0}};
      end else if (z_q[ZA-2]) begin
         zclamp_s = ZFAR;
      end else begin
         zclamp_s = z_q[ZW-1:0];
      end
      inside_s  = ~w0_q[WW-1] & ~w1_q[WW-1] & ~w2_q[WW-1];
      s1_v_d    = s0_v_q;
      s1_last_d = s0_v_q & (sx_q == XMAX) & (sy_q == XMAX);
      s1_x_d    = sx_q;
      s1_y_d    = sy_q;
      s1_in_d   = inside_s;
      s1_z_d    = zclamp_s;
   end

   // Depth compare selected by the latched function.
   always_comb begin
      case (func_q)
         DF_LESS:    zpass_s = (s1_z_q <  zbuf_q);
         DF_LEQUAL:  zpass_s = (s1_z_q <= zbuf_q);
         DF_ALWAYS:  zpass_s = 1'b1;
         DF_GREATER: zpass_s = (s1_z_q >  zbuf_q);
         default:    zpass_s = 1'b1;
      endcase
   end

   // S2 decision: a clear pass writes every pixel and resets depth to far.
   always_comb begin
      pass_s      = clr_q | (s1_in_q & zpass_s);
      wren_d      = s1_v_q & pass_s;
      we_s        = s1_v_q & (clr_q | (pass_s & dwr_q));
      wdata_s     = clr_q ? ZFAR : s1_z_q;
      color_out_d = wren_d ? col_q : color_out_q;
      x_out_d     = s1_v_q ? s1_x_q : x_out_q;
      y_out_d     = s1_v_q ? s1_y_q : y_out_q;
      s2_last_d   = s1_v_q & s1_last_q;
      if (start_ok_s) begin
         busy_d = 1'b1;
      end else if (s2_last_q) begin
         busy_d = 1'b0;
      end else begin
         busy_d = busy_q;
      end
      done_d = ~busy_d;
   end

   // Depth buffer: registered read feeding S1, write-back from the S2 decision; never reset.
   always_ff @(posedge clk) begin
      zbuf_q <= depth_mem[{sy_q, sx_q}];
      if (we_s) begin
         depth_mem[{s1_y_q, s1_x_q}] <= wdata_s;
      end
   end

   // Pipeline and configuration state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a01_q <= {AW{1'b0}};  a12_q <= {AW{1'b0}};  a20_q <= {AW{1'b0}};
         b01_q <= {BW{1'b0}};  b12_q <= {BW{1'b0}};  b20_q <= {BW{1'b0}};
         dzdx_q <= {ZW{1'b0}}; dzdy_q <= {ZW{1'b0}};
         col_q <= {CW{1'b0}};  clr_q <= 1'b0;  func_q <= 2'd0;  dwr_q <= 1'b0;
         sx_q <= {TILE_BITS{1'b0}};  sy_q <= {TILE_BITS{1'b0}};  s0_v_q <= 1'b0;
         w0_q <= {WW{1'b0}};  w1_q <= {WW{1'b0}};  w2_q <= {WW{1'b0}};
         r0_q <= {WW{1'b0}};  r1_q <= {WW{1'b0}};  r2_q <= {WW{1'b0}};
         z_q <= {ZA{1'b0}};   zr_q <= {ZA{1'b0}};
         s1_v_q <= 1'b0;  s1_last_q <= 1'b0;  s1_in_q <= 1'b0;
         s1_x_q <= {TILE_BITS{1'b0}};  s1_y_q <= {TILE_BITS{1'b0}};  s1_z_q <= {ZW{1'b0}};
         s2_last_q <= 1'b0;  wren_q <= 1'b0;  color_out_q <= {CW{1'b0}};
         x_out_q <= {TILE_BITS{1'b0}};  y_out_q <= {TILE_BITS{1'b0}};
         busy_q <= 1'b0;  done_q <= 1'b1;
      end else begin
         a01_q <= a01_d;  a12_q <= a12_d;  a20_q <= a20_d;
         b01_q <= b01_d;  b12_q <= b12_d;  b20_q <= b20_d;
         dzdx_q <= dzdx_d; dzdy_q <= dzdy_d;
         col_q <= col_d;  clr_q <= clr_d;  func_q <= func_d;  dwr_q <= dwr_d;
         sx_q <= sx_d;  sy_q <= sy_d;  s0_v_q <= s0_v_d;
         w0_q <= w0_d;  w1_q <= w1_d;  w2_q <= w2_d;
         r0_q <= r0_d;  r1_q <= r1_d;  r2_q <= r2_d;
         z_q <= z_d;    zr_q <= zr_d;
         s1_v_q <= s1_v_d;  s1_last_q <= s1_last_d;  s1_in_q <= s1_in_d;
         s1_x_q <= s1_x_d;  s1_y_q <= s1_y_d;  s1_z_q <= s1_z_d;
         s2_last_q <= s2_last_d;  wren_q <= wren_d;  color_out_q <= color_out_d;
         x_out_q <= x_out_d;  y_out_q <= y_out_d;
         busy_q <= busy_d;  done_q <= done_d;
      end
   end

   assign X         = x_out_q;
   assign Y         = y_out_q;
   assign wren      = wren_q;
   assign color_out = color_out_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: doc/tile_raster_pipe.md
Name: tile_raster_pipe

Overview:
- Parametrised, self-contained successor to the 32x32 tile renderer.
- Scans a square tile of 2^TILE_BITS x 2^TILE_BITS pixels in raster order, one pixel per clock.
- Per pixel: evaluates three incremental edge functions, interpolates and clamps depth, and performs a configurable depth test against an internal depth buffer.
- Emits a colour write stream for the tile colour buffer.
- New capabilities: selectable tile size and widths, four depth-compare functions, depth-write mask, and depth clamping.

Parameters:
- TILE_BITS, 5, log2 of tile side; N = 4^TILE_BITS pixels per pass.
- AW, 19, width of signed per-x edge increments A01/A12/A20.
- BW, 24, width of signed per-y edge increments B01/B12/B20.
- WW, 32, width of signed edge values w0/w1/w2.
- ZW, 27, depth width, unsigned; far value is 2^ZW-1.
- CW, 16, colour width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request; sampled only while idle.
- A01_in, A12_in, A20_in  input  AW each  signed edge x-steps.
- B01_in, B12_in, B20_in  input  BW each  signed edge y-steps.
- w0_in, w1_in, w2_in  input  WW each  signed edge values at pixel (0,0).
- z0_in  input  ZW  unsigned depth at (0,0).
- dzdx_in, dzdy_in  input  ZW each  signed depth steps.
- color_in  input  CW  pass colour.
- clear_in  input  1  pass is a clear.
- depth_func_in  input  2  compare function: 0 LESS, 1 LEQUAL, 2 ALWAYS, 3 GREATER.
- depth_write_in  input  1  depth-write mask.
- X  output  TILE_BITS  pixel x of current write.
- Y  output  TILE_BITS  pixel y of current write.
- wren  output  1  colour write strobe.
- color_out  output  CW  colour to write.
- busy  output  1  pass in progress or pipeline not drained.
- done  output  1  equals !busy.

Behaviour:
- Reset (rst low, async): all registers clear; X=0, Y=0, wren=0, color_out=0, busy=0, done=1.
- Depth RAM contents are not reset; they are undefined until a clear pass.
- Reset mid-pass aborts the pass immediately; no further wren.
- Idle: start=1 at edge t latches all *_in values; busy rises at t+1. start while busy is ignored, and inputs are not latched.
- Scan stage S0:
  - Pixel k (x = k mod side, y = k div side) is presented at cycle t+1+k, k = 0..N-1; x runs fastest.
  - Edge values: x step adds A; at row wrap, the row-start accumulator adds B and x resets to 0.
  - Depth: same scheme with dzdx/dzdy, accumulated in ZW+2-bit signed arithmetic.
- Inside test: w0>=0 and w1>=0 and w2>=0 (signed compare, no tie-break rule).
- Depth clamp before compare: accumulated z <0 becomes 0; z >2^ZW-1 becomes 2^ZW-1.
- S1: synchronous RAM read at address {y,x}; 1 cycle.
- S2 (cycle t+3+k):
  - Clear pass: wren=1, color_out=color; depth written as 2^ZW-1, ignoring edges, depth_func and depth_write.
  - Raster pass: pass = inside AND compare(zpix, zbuf) per depth_func, where LESS is zpix<zbuf, LEQUAL zpix<=zbuf, ALWAYS true, GREATER zpix>zbuf.
  - On pass: wren=1, color_out=color; depth RAM written with zpix only if depth_write=1.
  - On fail: wren=0, color_out holds its last value.
  - X/Y carry the S2 pixel address every active cycle. After the pass drains they hold the last address, (side-1, side-1).
- busy stays high through t+N+2 and drops at t+N+3. done is the inverse of busy.
- Next start is accepted from cycle t+N+3; the pipeline is empty by then, so no read-after-write forwarding is needed.
- Latency: start to first wren is 3 cycles; throughput is 1 pixel/clk; a pass occupies N+2 busy cycles.
- Wrap-around: the x/y counters are exactly TILE_BITS wide; the pass ends when k=N-1 is issued. Counters never wrap into a second pass.

Test Plan:
- Reset then clear (TILE_BITS=5, color=16'hF800, clear=1): wren high for 1024 consecutive cycles starting 3 after start, with X/Y raster order; busy falls 1027 cycles after start.
- After clear, raster A=0, B=0, w=1,1,1, z0=100, dz=0, LESS, depth_write=1, color=16'h07E0: 1024 writes. Repeating with LESS gives 0 writes; with LEQUAL gives 1024 writes.
- Half-plane w0_in=-15, A01=1, other edges large positive: wren only where x>=15, i.e. 17 writes per row, 544 total.
- Depth clamp: z0=2^27-1, dzdx=+5 after clear, GREATER: 0 writes since clamped z equals far. With z0=0, dzdx=-3, LESS: all 1024 written with depth 0.
- depth_write=0 pass at z=50, then LESS pass at z=60: both passes write all pixels (buffer still far).
- start pulsed at cycles t+1 and t+500 during a pass: ignored, no relatch; TILE_BITS=3 build completes a clear in 64 writes.
